// File: rtl/seg_scan.sv
// Multiplexed seven-segment scan driver (common anode, active-low selects and segments).
// Loads are staged in a pending set and committed at the frame boundary; define SEG_LZB_EN for leading-zero blanking.
module seg_scan #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_in,
  output logic [DIGITS-1:0]   sel,
  output logic [7:0]          seg_led,
  output logic                pending,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic                pending_q, pending_d;
  logic                frame_done_q;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                boundary;
  logic [DIGITS-1:0]   en_eff;

  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  assign boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the boundary cycle beats an older pending load and skips the pending set.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pending_d   = pending_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        act_data_d = data_in;
        act_dp_d   = dp_in;
        act_en_d   = en_in;
      end else if (pending_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        act_en_d   = pend_en_q;
      end
    end else if (load) begin
      pend_data_d = data_in;
      pend_dp_d   = dp_in;
      pend_en_d   = en_in;
      pending_d   = 1'b1;
    end
  end

`ifdef SEG_LZB_EN
  // Zeros left of the first nonzero (or dp-lit) enabled digit go dark; digit 0 always shows.
  always_comb begin : lzb_mask
    logic lead;
    lead   = 1'b1;
    en_eff = act_en_q;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && act_en_q[k]) begin
        if (act_data_q[4*k +: 4] == 4'h0 && !act_dp_q[k]) en_eff[k] = 1'b0;
        else lead = 1'b0;
      end
    end
  end
`else
  assign en_eff = act_en_q;
`endif

  always_comb begin : slot_out
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_en;
    logic [DIGITS-1:0] sel_on;
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    sel_on  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = act_data_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_en    = en_eff[k];
        sel_on[k] = 1'b0;
      end
    end
    if ((cnt_q < BLANK_END) || !cur_en) begin
      sel_d = '1;
      seg_d = 8'hFF;
    end else begin
      sel_d = sel_on;
      seg_d = {~cur_dp, font(cur_nib)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the register sets are reset too,
  // so the display is dark and any staged load is dropped when reset is asserted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pending_q    <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      frame_done_q <= 1'b0;
      sel_q        <= '1;
      seg_q        <= 8'hFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pending_q    <= pending_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      frame_done_q <= boundary;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign sel        = sel_q;
  assign seg_led    = seg_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: table of display loads with hand-derived per-slot patterns,
// plus boundary-load and mid-frame-reset sequences. Expectations track SEG_LZB_EN when defined.
module tb_seg_scan;

  localparam int DIGITS    = 6;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  localparam logic [35:0] SEL_ALL  = {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
  localparam logic [35:0] SEL_DARK = {6{6'h3F}};
  localparam logic [47:0] SEG_DARK = {6{8'hFF}};

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        load      = 1'b0;
  logic [23:0] data_in   = '0;
  logic [5:0]  dp_in     = '0;
  logic [5:0]  en_in     = '0;
  logic [5:0]  sel;
  logic [7:0]  seg_led;
  logic        pending;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
  } slot_t;

  typedef struct {
    string           name;
    logic [23:0]     data;
    logic [5:0]      dp;
    logic [5:0]      en;
    logic [5:0][5:0] sel;
    logic [5:0][7:0] seg;
  } vec_t;

  slot_t sb_q[$];
  vec_t  vecs[7];
  vec_t  vec_b;
  vec_t  vec_dark;

  seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .en_in     (en_in),
    .sel       (sel),
    .seg_led   (seg_led),
    .pending   (pending),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en);
    data_in = d;
    dp_in   = dp;
    en_in   = en;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic push_vec(input vec_t v);
    slot_t e;
    for (int s = 0; s < DIGITS; s++) begin
      e.sel = v.sel[s];
      e.seg = v.seg[s];
      sb_q.push_back(e);
    end
  endtask

  // Advance to the next frame_done cycle, checking pending on every cycle before it.
  task automatic wait_frame(input logic exp_pend);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      check("pending_while_waiting", 32'(pending), 32'(exp_pend));
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_done_timeout: got no pulse in %0d cycles, expected one", 3 * FRAME);
    end
  endtask

  // Called on a frame_done cycle: outputs for slot s, count c appear 1+8s+c cycles later.
  task automatic check_frame(input string tag);
    slot_t e;
    for (int s = 0; s < DIGITS; s++) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s scoreboard_empty: got no entry for slot %0d", tag, s);
        e.sel = 6'h3F;
        e.seg = 8'hFF;
      end else begin
        e = sb_q.pop_front();
      end
      for (int c = 0; c < SCAN_DIV; c++) begin
        tick();
        if (c < BLANK_CYC) begin
          check($sformatf("%s gap s%0d c%0d", tag, s, c), {18'h0, sel, seg_led}, {18'h0, 6'h3F, 8'hFF});
        end else begin
          check($sformatf("%s lit s%0d c%0d", tag, s, c), {18'h0, sel, seg_led}, {18'h0, e.sel, e.seg});
        end
      end
    end
    check($sformatf("%s frame_done_wrap", tag), 32'(frame_done), 32'd1);
  endtask

  initial begin
    vecs[0] = '{"digits",   24'h123456, 6'h00, 6'h3F, SEL_ALL, 48'hF9A4B0999282};
    vecs[1] = '{"en_dp",    24'h123456, 6'h02, 6'h3B,
                {6'h1F, 6'h2F, 6'h37, 6'h3F, 6'h3D, 6'h3E}, 48'hF9A4B0FF1282};
`ifdef SEG_LZB_EN
    vecs[2] = '{"lead_470", 24'h000470, 6'h00, 6'h3F,
                {6'h3F, 6'h3F, 6'h3F, 6'h3B, 6'h3D, 6'h3E}, 48'hFFFFFF99F8C0};
    vecs[3] = '{"all_zero", 24'h000000, 6'h00, 6'h3F,
                {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3E}, 48'hFFFFFFFFFFC0};
    vecs[5] = '{"zero_dp3", 24'h000000, 6'h08, 6'h3F,
                {6'h3F, 6'h3F, 6'h37, 6'h3B, 6'h3D, 6'h3E}, 48'hFFFF40C0C0C0};
`else
    vecs[2] = '{"lead_470", 24'h000470, 6'h00, 6'h3F, SEL_ALL, 48'hC0C0C099F8C0};
    vecs[3] = '{"all_zero", 24'h000000, 6'h00, 6'h3F, SEL_ALL, 48'hC0C0C0C0C0C0};
    vecs[5] = '{"zero_dp3", 24'h000000, 6'h08, 6'h3F, SEL_ALL, 48'hC0C040C0C0C0};
`endif
    vecs[4] = '{"hex_dp",   24'hABCDEF, 6'h3F, 6'h3F, SEL_ALL, 48'h08034621060E};
    vecs[6] = '{"eights",   24'h898989, 6'h00, 6'h3F, SEL_ALL, 48'h809080908090};
    vec_b    = '{"bnd_load", 24'h567123, 6'h00, 6'h3F, SEL_ALL, 48'h9282F8F9A4B0};
    vec_dark = '{"dark",     24'h000000, 6'h00, 6'h00, SEL_DARK, SEG_DARK};

    // Reset held, then one dark frame with no frame_done until the first wrap.
    repeat (3) @(posedge sys_clk);
    #1;
    check("in_reset", {22'h0, sel, seg_led, pending, frame_done}, {22'h0, 6'h3F, 8'hFF, 2'b00});
    sys_rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("reset_frame c%0d", i), {22'h0, sel, seg_led, pending, frame_done},
            {22'h0, 6'h3F, 8'hFF, 2'b00});
      tick();
    end
    check("first_wrap_frame_done", 32'(frame_done), 32'd1);

    // Mid-frame loads: old frame finishes, new values appear on the next frame.
    for (int v = 0; v < 7; v++) begin
      repeat (5) tick();
      drive_load(vecs[v].data, vecs[v].dp, vecs[v].en);
      push_vec(vecs[v]);
      check({vecs[v].name, " pending_set"}, 32'(pending), 32'd1);
      wait_frame(1'b1);
      check({vecs[v].name, " pending_clear"}, 32'(pending), 32'd0);
      check_frame(vecs[v].name);
    end

    // Load 10 cycles before the boundary, then a second load on the boundary cycle wins.
    repeat (37) tick();
    drive_load(24'hFFFFFF, 6'h00, 6'h3F);
    check("bnd first_load pending", 32'(pending), 32'd1);
    repeat (9) tick();
    drive_load(vec_b.data, vec_b.dp, vec_b.en);
    push_vec(vec_b);
    check("bnd frame_done", 32'(frame_done), 32'd1);
    check("bnd pending_clear", 32'(pending), 32'd0);
    check_frame(vec_b.name);

    // Reset while a load is pending: display stays dark afterwards.
    repeat (5) tick();
    drive_load(24'h123456, 6'h00, 6'h3F);
    check("rst pending_before", 32'(pending), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst async_clear", {22'h0, sel, seg_led, pending, frame_done}, {22'h0, 6'h3F, 8'hFF, 2'b00});
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    push_vec(vec_dark);
    wait_frame(1'b0);
    check("rst pending_after", 32'(pending), 32'd0);
    check_frame("after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
